// File: rtl/byte_feeder_pkg.sv
// Shared types and defaults for the byte feeder and its occupancy counter.
//   feeder_state_e : write FSM states SHIFT / ISSUE / GAP
//   byte_t         : one stack byte
package byte_feeder_pkg;

  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    SHIFT,
    ISSUE,
    GAP
  } feeder_state_e;

endpackage

// File: rtl/occ_counter.sv
// Up/down saturating occupancy counter for the downstream byte stack.
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   inc               : a byte was written this cycle
//   dec               : a byte was read this cycle
//   clr_err           : synchronous clear of the sticky underflow flag
//   count             : current occupancy (0..DEPTH)
//   full, empty       : count == DEPTH, count == 0
//   underflow         : sticky, a read was seen with count == 0
module occ_counter
  import byte_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned OCC_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr_err,
  output logic [OCC_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             underflow
);

  logic [OCC_W-1:0] count_q, count_d;
  logic             uf_q, uf_d;
  logic             uf_event;

  always_comb begin
    count_d  = count_q;
    uf_event = 1'b0;
    if (inc && !dec) begin
      if (count_q != OCC_W'(DEPTH)) count_d = count_q + OCC_W'(1);
    end else if (dec && !inc) begin
      if (count_q == '0) uf_event = 1'b1;
      else               count_d  = count_q - OCC_W'(1);
    end
    // A fresh event in the clearing cycle keeps the flag set.
    uf_d = (uf_q & ~clr_err) | uf_event;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      uf_q    <= uf_d;
    end
  end

  assign count     = count_q;
  assign full      = (count_q == OCC_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign underflow = uf_q;

endmodule

// File: rtl/byte_feeder.sv
// Serial-to-byte feeder for the 8-deep byte stack.
// Deserialises s_data (LSB first) into a one-entry hold register and issues a
// one-cycle write strobe only when the stack has room, tracking occupancy from
// its own writes and a tap of the stack's read strobe.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   s_data, s_valid       : serial bit and its qualifier
//   rd_tap                : copy of the stack read strobe
//   clr_err               : synchronous clear of sticky error flags
//   write, data_in        : write strobe and byte to the stack
//   full, empty, occupancy: stack fill estimate
//   overrun, underflow    : sticky error flags
//   parity_err            : sticky parity error (only with BYTE_FEEDER_PARITY_EN)
// Option: define BYTE_FEEDER_PARITY_EN to append an even-parity bit to each frame.
module byte_feeder
  import byte_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned OCC_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_data,
  input  logic             s_valid,
  input  logic             rd_tap,
  input  logic             clr_err,
  output logic             write,
  output logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] occupancy,
  output logic             overrun,
  output logic             underflow
`ifdef BYTE_FEEDER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef BYTE_FEEDER_PARITY_EN
  localparam int unsigned FrameBits = WIDTH + 1;
`else
  localparam int unsigned FrameBits = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(FrameBits);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             write_q, write_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;
  feeder_state_e    state_q, state_d;

  logic             frame_done, frame_ok, hold_take, accept, ov_event;
  logic [WIDTH-1:0] frame_byte;

  // Shifter: bits land at their final position, so the frame is complete
  // as soon as the last bit is written.
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    frame_done = 1'b0;
    frame_ok   = 1'b1;
    if (s_valid) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (bit_cnt_q == CntW'(i)) shift_d[i] = s_data;
      end
      if (bit_cnt_q == CntW'(FrameBits - 1)) begin
        bit_cnt_d  = '0;
        frame_done = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CntW'(1);
      end
`ifdef BYTE_FEEDER_PARITY_EN
      if (bit_cnt_q == CntW'(WIDTH)) frame_ok = ~((^shift_q) ^ s_data);
`endif
    end
    frame_byte = shift_d;
  end

  // The hold is emptied on the edge that leaves ISSUE, so a byte completing
  // on that edge can take its place.
  assign hold_take = (state_q == ISSUE);
  assign accept    = frame_done & frame_ok & (~hold_valid_q | hold_take);
  assign ov_event  = frame_done & frame_ok & hold_valid_q & ~hold_take;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (accept) begin
      hold_d       = frame_byte;
      hold_valid_d = 1'b1;
    end else if (hold_take) begin
      hold_valid_d = 1'b0;
    end
    overrun_d = (overrun_q & ~clr_err) | ov_event;
  end

  // Write FSM. The strobe is registered, so it is visible during the cycle
  // after ISSUE; by the next SHIFT cycle occupancy already includes it.
  always_comb begin
    state_d = state_q;
    write_d = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      SHIFT: begin
        if (hold_valid_q && !full) state_d = ISSUE;
      end
      ISSUE: begin
        write_d = 1'b1;
        data_d  = hold_q;
        state_d = GAP;
      end
      GAP: begin
        state_d = SHIFT;
      end
      default: state_d = SHIFT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      write_q      <= 1'b0;
      data_q       <= '0;
      overrun_q    <= 1'b0;
      state_q      <= SHIFT;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      write_q      <= write_d;
      data_q       <= data_d;
      overrun_q    <= overrun_d;
      state_q      <= state_d;
    end
  end

`ifdef BYTE_FEEDER_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity_err_q <= 1'b0;
    else          parity_err_q <= (parity_err_q & ~clr_err) | (frame_done & ~frame_ok);
  end

  assign parity_err = parity_err_q;
`endif

  occ_counter #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_occ (
    .clk       (clk),
    .reset_n   (reset_n),
    .inc       (write_q),
    .dec       (rd_tap),
    .clr_err   (clr_err),
    .count     (occupancy),
    .full      (full),
    .empty     (empty),
    .underflow (underflow)
  );

  assign write   = write_q;
  assign data_in = data_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_byte_feeder.sv
// Self-checking bench for byte_feeder: directed scenarios plus a randomized
// phase, with a queue of expected bytes checked by a negedge monitor and a
// transaction-level occupancy model.
module tb_byte_feeder;
  import byte_feeder_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_data = 1'b0;
  logic       s_valid = 1'b0;
  logic       rd_tap = 1'b0;
  logic       clr_err = 1'b0;
  logic       write;
  logic [7:0] data_in;
  logic       full, empty, overrun, underflow;
  logic [3:0] occupancy;
`ifdef BYTE_FEEDER_PARITY_EN
  logic       parity_err;
`endif

  byte_feeder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .rd_tap    (rd_tap),
    .clr_err   (clr_err),
    .write     (write),
    .data_in   (data_in),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy),
    .overrun   (overrun),
`ifdef BYTE_FEEDER_PARITY_EN
    .parity_err(parity_err),
`endif
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  byte_t exp_q[$];
  int    occ_m = 0;
  bit    uf_m = 1'b0;
  int    wr_cnt = 0;
  bit    prev_write = 1'b0;
  bit    rd_mode = 1'b0;
  bit    rand_gaps = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Monitor: inputs and outputs are both stable mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        occ_m      = 0;
        uf_m       = 1'b0;
        prev_write = 1'b0;
      end else begin
        chk("occupancy", int'(occupancy), occ_m);
        chk("full", int'(full), int'(occ_m == DEPTH));
        chk("empty", int'(empty), int'(occ_m == 0));
        chk("underflow", int'(underflow), int'(uf_m));
        if (write) begin
          wr_cnt++;
          chk("write_back_to_back", int'(prev_write), 0);
          chk("write_while_full", int'(occ_m == DEPTH), 0);
          if (exp_q.size() == 0) chk("unexpected_write", int'(data_in), -1);
          else                   chk("data_in", int'(data_in), int'(exp_q.pop_front()));
        end
        prev_write = write;
        // Predict the state after the coming edge.
        if (write && !rd_tap) begin
          if (occ_m < DEPTH) occ_m++;
          uf_m = uf_m && !clr_err;
        end else if (rd_tap && !write) begin
          if (occ_m > 0) begin
            occ_m--;
            uf_m = uf_m && !clr_err;
          end else begin
            uf_m = 1'b1;
          end
        end else begin
          uf_m = uf_m && !clr_err;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    if (rd_mode) rd_tap = (occ_m >= 5) || (occ_m > 0 && $urandom_range(0, 1) == 1);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Sends one frame LSB first; in parity builds an even-parity bit follows,
  // inverted when bad_par is set.
  task automatic send_byte(input byte_t b, input bit bad_par);
    for (int i = 0; i < 8; i++) begin
      if (rand_gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_data  = 1'($urandom_range(0, 1));
        step();
      end
      s_valid = 1'b1;
      s_data  = b[i];
      step();
    end
`ifdef BYTE_FEEDER_PARITY_EN
    s_valid = 1'b1;
    s_data  = (^b) ^ bad_par;
    step();
`else
    if (bad_par) $display("note: parity request ignored in this build");
`endif
    s_valid = 1'b0;
    s_data  = 1'b0;
  endtask

  task automatic drain();
    idle(12);
    for (int i = 0; i < 40; i++) begin
      if (occ_m == 0) break;
      rd_tap = 1'b1;
      tick();
    end
    rd_tap = 1'b0;
    tick();
    chk("drain_done", occ_m, 0);
  endtask

  int w0;

  initial begin
    // Reset values.
    #3;
    chk("rst_write", int'(write), 0);
    chk("rst_data_in", int'(data_in), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_underflow", int'(underflow), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Partial byte then reset: those bits must be discarded.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_rst_write", int'(write), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_occ", int'(occupancy), 0);

    // 0xA5: strobe exactly two cycles after the edge sampling its last bit.
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b0);
    chk("lat_write_e0", int'(write), 0);
    tick();
    chk("lat_write_e1", int'(write), 0);
    tick();
    chk("lat_write_e2", int'(write), 1);
    chk("lat_data_e2", int'(data_in), 'hA5);
    tick();
    chk("lat_write_pulse_len", int'(write), 0);
    drain();

    // Fill: nine bytes, no reads.
    w0 = wr_cnt;
    for (int k = 1; k <= 9; k++) begin
      exp_q.push_back(byte_t'(k));
      send_byte(byte_t'(k), 1'b0);
    end
    idle(10);
    chk("fill_writes", wr_cnt - w0, 8);
    chk("fill_occ", int'(occupancy), 8);
    chk("fill_full", int'(full), 1);
    rd_tap = 1'b1;
    tick();
    rd_tap = 1'b0;
    idle(6);
    chk("fill_writes_after_rd", wr_cnt - w0, 9);
    chk("fill_full_again", int'(full), 1);

    // Overrun: hold 0x33 while full, then 0x5A is dropped.
    exp_q.push_back(8'h33);
    send_byte(8'h33, 1'b0);
    idle(2);
    chk("ovr_before", int'(overrun), 0);
    send_byte(8'h5A, 1'b0);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_no_write", wr_cnt - w0, 9);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovr_cleared", int'(overrun), 0);
    rd_tap = 1'b1;
    tick();
    rd_tap = 1'b0;
    idle(6);
    chk("ovr_held_written", wr_cnt - w0, 10);
    drain();

    // Write and read in the same cycle at occupancy 3.
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(byte_t'(8'hC0 + k));
      send_byte(byte_t'(8'hC0 + k), 1'b0);
    end
    idle(6);
    chk("sim_occ3", int'(occupancy), 3);
    exp_q.push_back(8'h77);
    send_byte(8'h77, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (write) break;
      tick();
    end
    chk("sim_write_seen", int'(write), 1);
    rd_tap = 1'b1;
    tick();
    rd_tap = 1'b0;
    chk("sim_occ_unchanged", int'(occupancy), 3);
    drain();

    // Underflow.
    rd_tap = 1'b1;
    tick();
    rd_tap = 1'b0;
    chk("uf_set", int'(underflow), 1);
    chk("uf_occ", int'(occupancy), 0);
    chk("uf_empty", int'(empty), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("uf_cleared", int'(underflow), 0);

`ifdef BYTE_FEEDER_PARITY_EN
    w0 = wr_cnt;
    exp_q.push_back(8'h03);
    send_byte(8'h03, 1'b0);
    idle(6);
    chk("par_good_written", wr_cnt - w0, 1);
    chk("par_good_no_err", int'(parity_err), 0);
    send_byte(8'h03, 1'b1);
    chk("par_bad_err", int'(parity_err), 1);
    idle(6);
    chk("par_bad_no_write", wr_cnt - w0, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("par_err_cleared", int'(parity_err), 0);
    drain();
`endif

    // Randomized traffic with random reads; the stack never fills here, so
    // every byte sent must come out in order.
    rd_mode   = 1'b1;
    rand_gaps = 1'b1;
    for (int k = 0; k < 150; k++) begin
      byte_t b;
      b = byte_t'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(12);
    rd_mode   = 1'b0;
    rand_gaps = 1'b0;
    rd_tap    = 1'b0;
    drain();
    chk("rand_no_overrun", int'(overrun), 0);
    chk("queue_empty_at_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
